// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module : calc_pkg
// Brief  : Shared types and constants for the calculator display stage.
// Rev    : 1.0
// ============================================================================
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned CONV_LEN   = 6;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module : seg7_decode
// Brief  : BCD nibble to active-low 7-segment pattern; codes above 9 blank.
// Rev    : 1.0
// ============================================================================
module seg7_decode
    import calc_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/calc_display.sv
`default_nettype none
// ============================================================================
// Module : calc_display
// Brief  : Binary-to-BCD conversion and 4-digit multiplexed 7-segment driver.
// Rev    : 1.0
// ============================================================================
module calc_display
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [5:0] value,
    input  logic       neg,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int c_REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_REF_W-1:0] c_REF_MAX = c_REF_W'(REFRESH_DIV - 1);
    localparam int c_IDX_W = $clog2(NUM_DIGITS);
    localparam int c_CNT_W = $clog2(CONV_LEN);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CONV_LEN - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_busy;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [5:0]           r_bin;
    logic [7:0]           r_bcd;
    logic [7:0]           w_bcd_adj;
    logic                 r_neg;
    logic                 r_nonzero;
    logic [3:0]           r_units;
    logic [3:0]           r_tens;
    logic                 r_sign;
    logic [c_REF_W-1:0]   r_refresh;
    logic [c_IDX_W-1:0]   r_idx;
    logic [3:0]           r_an;
    logic [6:0]           r_seg;
    logic [6:0]           w_units_seg;
    logic [6:0]           w_tens_seg;
    logic [6:0]           w_digit_seg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (load) w_next_state = SHIFT;
            SHIFT:   if (r_cnt == c_CNT_LAST) w_next_state = LATCH;
            LATCH:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    generate
        for (genvar g = 0; g < 2; g++) begin : g_adj
            assign w_bcd_adj[g*4 +: 4] = (r_bcd[g*4 +: 4] >= 4'd5) ?
                                         r_bcd[g*4 +: 4] + 4'd3 : r_bcd[g*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_neg     <= 1'b0;
            r_nonzero <= 1'b0;
            r_units   <= '0;
            r_tens    <= '0;
            r_sign    <= 1'b0;
        end else begin
            r_busy <= (w_next_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_bin     <= value;
                        r_neg     <= neg;
                        r_nonzero <= (value != 6'd0);
                        r_bcd     <= '0;
                        r_cnt     <= '0;
                    end
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_cnt          <= r_cnt + 1'b1;
                end
                LATCH: begin
                    // Display registers only move here, never mid-conversion
                    r_units <= r_bcd[3:0];
                    r_tens  <= r_bcd[7:4];
                    r_sign  <= r_neg & r_nonzero;
                end
                default: ;
            endcase
        end
    end

    seg7_decode u_units_dec (.i_bcd(r_units), .o_seg(w_units_seg));
    seg7_decode u_tens_dec  (.i_bcd(r_tens),  .o_seg(w_tens_seg));

    always_comb begin
        w_digit_seg = SEG_BLANK;
        case (r_idx)
            2'd0:    w_digit_seg = w_units_seg;
            2'd1:    w_digit_seg = (r_tens == 4'd0) ? SEG_BLANK : w_tens_seg;
            2'd2:    w_digit_seg = r_sign ? SEG_MINUS : SEG_BLANK;
            default: w_digit_seg = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_an      <= 4'b1111;
            r_seg     <= SEG_BLANK;
        end else begin
            if (r_refresh == c_REF_MAX) begin
                r_refresh <= '0;
                r_idx     <= r_idx + 1'b1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_digit_seg;
        end
    end

    assign busy = r_busy;
    assign seg  = r_seg;
    assign an   = r_an;
    assign dp   = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_calc_display.sv
`default_nettype none
// ============================================================================
// Module : tb_calc_display
// Brief  : Directed scoreboard bench for calc_display with a short refresh.
// Rev    : 1.0
// ============================================================================
module tb_calc_display;
    import calc_pkg::*;

    localparam int c_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [5:0] value;
    logic       neg;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_pass  = 0;
    int n_total = 0;

    logic [10:0] disp_q[$];
    logic        busy_q[$];

    calc_display #(.REFRESH_DIV(c_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (value),
        .neg   (neg),
        .busy  (busy),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Pushes one frame of expectations, aligns to digit 0, then pops per slot
    task automatic check_frame(input string tag, input logic [6:0] s0,
                               input logic [6:0] s1, input logic [6:0] s2);
        logic [10:0] e;
        int waited;
        disp_q.push_back({4'b1110, s0});
        disp_q.push_back({4'b1101, s1});
        disp_q.push_back({4'b1011, s2});
        disp_q.push_back({4'b0111, SEG_BLANK});
        waited = 0;
        while (an !== 4'b1110 && waited < 4 * c_DIV + 4) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_sync"}, {28'd0, an}, 32'hE);
        for (int i = 0; i < 4; i++) begin
            e = disp_q.pop_front();
            chk($sformatf("%s_d%0d", tag, i), {21'd0, an, seg}, {21'd0, e});
            repeat (c_DIV) @(negedge clk);
        end
    endtask

    // Drives a load sampled at the next rising edge, then checks busy per cycle
    task automatic do_load(input string tag, input logic [5:0] v, input logic n);
        load  = 1'b1;
        value = v;
        neg   = n;
        for (int i = 0; i < 8; i++) busy_q.push_back(i < 7);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            load = 1'b0;
            chk($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, {31'd0, busy_q.pop_front()});
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        neg   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an",   {28'd0, an},   32'hF);
        chk("rst_seg",  {25'd0, seg},  {25'd0, SEG_BLANK});
        chk("rst_dp",   {31'd0, dp},   32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Cycle-accurate scan after release: each digit held exactly c_DIV cycles
        rst_n = 1'b1;
        for (int n = 0; n < 4 * c_DIV; n++) begin
            logic [3:0] a;
            a = ~(4'b0001 << (n / c_DIV));
            disp_q.push_back({a, (n < c_DIV) ? SEG_0 : SEG_BLANK});
        end
        for (int n = 0; n < 4 * c_DIV; n++) begin
            logic [10:0] e;
            @(negedge clk);
            e = disp_q.pop_front();
            chk($sformatf("scan%0d", n), {21'd0, an, seg}, {21'd0, e});
        end

        do_load("v63", 6'd63, 1'b0);
        check_frame("v63", SEG_3, SEG_6, SEG_BLANK);

        do_load("v5n", 6'd5, 1'b1);
        check_frame("v5n", SEG_5, SEG_BLANK, SEG_MINUS);

        do_load("v0n", 6'd0, 1'b1);
        check_frame("v0n", SEG_0, SEG_BLANK, SEG_BLANK);

        // Second load three cycles in must be dropped, not queued
        load  = 1'b1;
        value = 6'd42;
        neg   = 1'b0;
        for (int i = 0; i < 12; i++) busy_q.push_back(i < 7);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (i == 2) begin
                load  = 1'b1;
                value = 6'd9;
                neg   = 1'b1;
            end
            chk($sformatf("v42_busy%0d", i), {31'd0, busy}, {31'd0, busy_q.pop_front()});
        end
        load = 1'b0;
        check_frame("v42", SEG_2, SEG_4, SEG_BLANK);

        // Reset lands on the 4th conversion cycle
        load  = 1'b1;
        value = 6'd63;
        neg   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load = 1'b0;
            chk($sformatf("abort_busy%0d", i), {31'd0, busy}, 32'd1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rst_busy", {31'd0, busy}, 32'd0);
        chk("abort_rst_an",   {28'd0, an},   32'hF);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("abort_idle%0d", i), {31'd0, busy}, 32'd0);
        end
        check_frame("abort", SEG_0, SEG_BLANK, SEG_BLANK);
        chk("end_dp", {31'd0, dp}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
